// File: rtl/hjdebug_seq.sv
// Autonomous register-port master for the logic-analyser debug core: loads trigger
// words, arms, polls for completion, reads the depth and drains samples to a stream.
module hjdebug_seq #(
  parameter int N       = 1,
  parameter int TRIGW   = 1,
  parameter int POLLGAP = 64,
  parameter int ACKTO   = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_start,
  input  logic        cmd_abort,
  input  logic        cfg_trans,
  input  logic [15:0] cfg_tpos,
  input  logic        trig_we,
  input  logic [5:0]  trig_addr,
  input  logic [31:0] trig_wdata,
  output logic        dbg_req,
  output logic        dbg_wr,
  output logic [11:0] dbg_addr,
  output logic [31:0] dbg_wdata,
  input  logic        dbg_ack,
  input  logic        dbg_err,
  input  logic [31:0] dbg_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        error
);
  localparam int IW = (TRIGW > 1) ? $clog2(TRIGW) : 1;
  localparam int CW = $clog2(ACKTO + 1);
  localparam int GW = $clog2(POLLGAP + 1);
  localparam logic [CW-1:0] ACK_LAST = CW'(ACKTO - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLLGAP - 1);
  localparam logic [6:0]    TRIG_N   = 7'(TRIGW);
  localparam logic [5:0]    TRIG_TOP = 6'(TRIGW - 1);
  localparam logic [31:0]   WPS      = 32'((N + 31) / 32);
  localparam logic [11:0]   A_CTRL   = 12'd0;
  localparam logic [11:0]   A_DEPTH  = 12'd4;
  localparam logic [11:0]   A_DATA   = 12'd8;
  localparam logic [11:0]   A_TRIG   = 12'd12;

  typedef enum logic [3:0] {IDLE, LOAD, ARM, POLL, PGAP, SIZE, DRAIN, FIN, ABT, ERR} state_t;

  state_t         state, nstate;
  logic           pend;
  logic [CW-1:0]  ack_cnt;
  logic [5:0]     idx;
  logic [GW-1:0]  gap_cnt;
  logic [31:0]    remaining;
  logic           abort_q;
  logic [15:0]    tpos_q;
  logic           trans_q;
  logic [31:0]    tbuf [2**IW];

  logic           ack_ok, tmo, aborting, accept_start;
  logic           want, issue, iss_wr;
  logic [11:0]    iss_addr;
  logic [31:0]    iss_wdata;
  logic [31:0]    size_total;

  assign busy         = (state != IDLE) && (state != FIN) && (state != ERR);
  assign done         = (state == FIN);
  assign ack_ok       = pend && dbg_ack;
  assign tmo          = pend && !dbg_ack && (ack_cnt == ACK_LAST);
  assign aborting     = (abort_q || cmd_abort) && busy && (state != ABT);
  assign accept_start = (state == IDLE) && cmd_start && !cmd_abort;
  assign size_total   = {16'd0, dbg_rdata[15:0]} * WPS;

  always_comb begin
    nstate    = state;
    want      = 1'b0;
    iss_wr    = 1'b0;
    iss_addr  = A_CTRL;
    iss_wdata = 32'd0;
    case (state)
      IDLE:  if (accept_start) nstate = LOAD;
      LOAD: begin
        want      = 1'b1;
        iss_wr    = 1'b1;
        iss_addr  = A_TRIG;
        iss_wdata = tbuf[idx[IW-1:0]];
        if (ack_ok && idx == 6'd0) nstate = ARM;
      end
      ARM: begin
        want      = 1'b1;
        iss_wr    = 1'b1;
        iss_wdata = {tpos_q, 7'b0, trans_q, 6'b0, 1'b0, 1'b1};
        if (ack_ok) nstate = POLL;
      end
      POLL: begin
        want = 1'b1;
        if (ack_ok) nstate = dbg_rdata[2] ? SIZE : PGAP;
      end
      PGAP:  if (gap_cnt == GAP_LAST) nstate = POLL;
      SIZE: begin
        want     = 1'b1;
        iss_addr = A_DEPTH;
        if (ack_ok) nstate = (size_total == 32'd0) ? FIN : DRAIN;
      end
      DRAIN: begin
        // Next read only once the held word is gone or leaves this cycle.
        want     = (remaining != 32'd0) && (!out_valid || out_ready);
        iss_addr = A_DATA;
        if (out_valid && out_ready && out_last) nstate = FIN;
      end
      ABT: begin
        want      = 1'b1;
        iss_wr    = 1'b1;
        iss_wdata = 32'h2;
        if (ack_ok) nstate = IDLE;
      end
      FIN:     nstate = IDLE;
      ERR:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
    // An outstanding ack is always awaited before aborting; its status is ignored.
    if (tmo)                                       nstate = ERR;
    else if (aborting)                             nstate = (pend && !ack_ok) ? state : ABT;
    else if (ack_ok && dbg_err && state != ABT)    nstate = ERR;
    issue = want && !pend && (nstate == state);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      pend      <= 1'b0;
      ack_cnt   <= '0;
      dbg_req   <= 1'b0;
      dbg_wr    <= 1'b0;
      dbg_addr  <= 12'd0;
      dbg_wdata <= 32'd0;
      idx       <= 6'd0;
      gap_cnt   <= '0;
      remaining <= 32'd0;
      abort_q   <= 1'b0;
      error     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 32'd0;
    end else begin
      state   <= nstate;
      dbg_req <= issue;
      if (issue) begin
        pend      <= 1'b1;
        ack_cnt   <= '0;
        dbg_wr    <= iss_wr;
        dbg_addr  <= iss_addr;
        dbg_wdata <= iss_wdata;
      end else if (ack_ok || tmo) begin
        pend <= 1'b0;
      end else if (pend) begin
        ack_cnt <= ack_cnt + CW'(1);
      end

      if (state == IDLE)             idx <= TRIG_TOP;
      else if (state == LOAD && ack_ok) idx <= idx - 6'd1;

      gap_cnt <= (state == PGAP) ? gap_cnt + GW'(1) : '0;

      if (state == SIZE && ack_ok)       remaining <= size_total;
      else if (state == DRAIN && ack_ok) remaining <= remaining - 32'd1;

      if (state == IDLE)                abort_q <= 1'b0;
      else if (cmd_abort && busy)       abort_q <= 1'b1;

      if (accept_start)         error <= 1'b0;
      else if (nstate == ERR)   error <= 1'b1;

      if (nstate == ABT || nstate == ERR) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (state == DRAIN && ack_ok) begin
        out_valid <= 1'b1;
        out_data  <= dbg_rdata;
        out_last  <= (remaining == 32'd1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // Configuration and trigger storage carry no reset; they are rewritten before use.
  always_ff @(posedge clk) begin
    if (accept_start) begin
      tpos_q  <= cfg_tpos;
      trans_q <= cfg_trans;
    end
    if (trig_we && !busy && ({1'b0, trig_addr} < TRIG_N))
      tbuf[trig_addr[IW-1:0]] <= trig_wdata;
  end

endmodule

// File: tb/tb_hjdebug_seq.sv
// Directed bench for hjdebug_seq: a behavioural debug-core responder plus stream
// consumer, with per-scenario tasks checking the register traffic and the stream.
module tb_hjdebug_seq;
  localparam int ACKTO = 64;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        cmd_start = 1'b0, cmd_abort = 1'b0, cfg_trans = 1'b0;
  logic [15:0] cfg_tpos = 16'd0;
  logic        trig_we = 1'b0;
  logic [5:0]  trig_addr = 6'd0;
  logic [31:0] trig_wdata = 32'd0;
  logic        dbg_req, dbg_wr;
  logic [11:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack, dbg_err;
  logic [31:0] dbg_rdata;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        busy, done, error;

  hjdebug_seq #(.N(40), .TRIGW(2), .POLLGAP(64), .ACKTO(ACKTO)) dut (
    .clk(clk), .rstn(rstn), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cfg_trans(cfg_trans), .cfg_tpos(cfg_tpos), .trig_we(trig_we),
    .trig_addr(trig_addr), .trig_wdata(trig_wdata), .dbg_req(dbg_req),
    .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic wr; logic [11:0] addr; logic [31:0] wdata; int cyc; } txn_t;
  txn_t        log_q[$];
  logic [32:0] words[$];

  int          total = 0, passed = 0;
  int          lat = 1, avail_at = 0, poll_cnt = 0, data_cnt = 0;
  logic [15:0] depth = 16'd0;
  logic        no_ack = 1'b0, err_arm = 1'b0, rdy_mode = 1'b0;

  // Debug-core responder: one transaction at a time, ack after lat cycles.
  initial begin : core
    txn_t        t;
    logic [31:0] rd;
    logic        er;
    dbg_ack = 1'b0; dbg_err = 1'b0; dbg_rdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (dbg_req) begin
        t.wr = dbg_wr; t.addr = dbg_addr; t.wdata = dbg_wdata; t.cyc = cyc;
        log_q.push_back(t);
        if (!no_ack) begin
          rd = 32'd0; er = 1'b0;
          if (!t.wr && t.addr == 12'd0) begin
            rd = (poll_cnt >= avail_at) ? 32'h4 : 32'h0;
            poll_cnt++;
          end else if (!t.wr && t.addr == 12'd4) begin
            rd = {16'd0, depth};
          end else if (!t.wr && t.addr == 12'd8) begin
            rd = 32'hD000_0000 + 32'(data_cnt);
            data_cnt++;
          end else if (t.wr && t.addr == 12'd0 && t.wdata[0] && err_arm) begin
            er = 1'b1;
          end
          repeat (lat) @(posedge clk);
          #1; dbg_ack = 1'b1; dbg_err = er; dbg_rdata = rd;
          @(posedge clk); #1; dbg_ack = 1'b0; dbg_err = 1'b0; dbg_rdata = 32'd0;
        end
      end
    end
  end

  initial begin : consumer
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rdy_mode ? ~out_ready : 1'b1;
    end
  end

  int          done_cnt = 0, done_cyc = 0, hs_cyc = 0, valid_seen = 0, unstable = 0, dbl_req = 0;
  logic        hold_prev = 1'b0, prev_last = 1'b0, req_prev = 1'b0;
  logic [31:0] prev_data = 32'd0;
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      words.push_back({out_last, out_data});
      hs_cyc <= cyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (out_valid) valid_seen <= valid_seen + 1;
    if (dbg_req && req_prev) dbl_req <= dbl_req + 1;
    if (hold_prev && (!out_valid || out_data !== prev_data || out_last !== prev_last))
      unstable <= unstable + 1;
    hold_prev <= out_valid && !out_ready;
    prev_data <= out_data;
    prev_last <= out_last;
    req_prev  <= dbg_req;
  end

  task automatic pulse_start(input logic [15:0] tp, input logic tr);
    @(posedge clk); #1; cmd_start = 1'b1; cfg_tpos = tp; cfg_trans = tr;
    @(posedge clk); #1; cmd_start = 1'b0;
  endtask

  task automatic write_trig(input logic [5:0] a, input logic [31:0] d);
    @(posedge clk); #1; trig_we = 1'b1; trig_addr = a; trig_wdata = d;
    @(posedge clk); #1; trig_we = 1'b0;
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, error, dbg_req, dbg_wr, out_valid, out_last} !== 7'b0)
      $display("FAIL reset_ctrl: got %b want 0000000", {busy, done, error, dbg_req, dbg_wr, out_valid, out_last});
    else passed++;
    total++;
    if (dbg_addr !== 12'd0 || dbg_wdata !== 32'd0)
      $display("FAIL reset_bus: got addr %0h wdata %0h want 0 0", dbg_addr, dbg_wdata);
    else passed++;
    total++;
    if (out_data !== 32'd0) $display("FAIL reset_data: got %0h want 0", out_data);
    else passed++;
  endtask

  task automatic test_full();
    int lb, wb, db, bd, ub, rb, n, nrd0, nrd8;
    int pc[3];
    logic [32:0] exp;
    write_trig(6'd0, 32'hAAAA_0001);
    write_trig(6'd1, 32'hBBBB_0002);
    write_trig(6'd5, 32'hFFFF_FFFF);
    lb = log_q.size(); wb = words.size(); db = done_cnt; ub = unstable; rb = dbl_req;
    bd = data_cnt;
    depth = 16'd3; avail_at = poll_cnt + 2; rdy_mode = 1'b1; lat = 1;
    pulse_start(16'h0010, 1'b0);
    total++;
    if (busy !== 1'b1) $display("FAIL full_busy: got %b want 1", busy);
    else passed++;
    write_trig(6'd0, 32'hDEAD_BEEF);
    n = 0;
    while (done_cnt == db && n < 3000) begin
      if (n == 100) pulse_start(16'h0010, 1'b0);
      @(negedge clk); n++;
    end
    repeat (4) @(negedge clk);
    total++;
    if (log_q.size() - lb !== 13) $display("FAIL full_txn_count: got %0d want 13", log_q.size() - lb);
    else passed++;
    if (log_q.size() - lb >= 13) begin
      total++;
      if ({log_q[lb].wr, log_q[lb].addr, log_q[lb].wdata} !== {1'b1, 12'd12, 32'hBBBB_0002})
        $display("FAIL full_load0: got %b %0d %h want 1 12 bbbb0002", log_q[lb].wr, log_q[lb].addr, log_q[lb].wdata);
      else passed++;
      total++;
      if ({log_q[lb+1].wr, log_q[lb+1].addr, log_q[lb+1].wdata} !== {1'b1, 12'd12, 32'hAAAA_0001})
        $display("FAIL full_load1: got %b %0d %h want 1 12 aaaa0001", log_q[lb+1].wr, log_q[lb+1].addr, log_q[lb+1].wdata);
      else passed++;
      total++;
      if ({log_q[lb+2].wr, log_q[lb+2].addr, log_q[lb+2].wdata} !== {1'b1, 12'd0, 32'h0010_0001})
        $display("FAIL full_arm: got %b %0d %h want 1 0 00100001", log_q[lb+2].wr, log_q[lb+2].addr, log_q[lb+2].wdata);
      else passed++;
      total++;
      if ({log_q[lb+6].wr, log_q[lb+6].addr} !== {1'b0, 12'd4})
        $display("FAIL full_size_read: got %b %0d want 0 4", log_q[lb+6].wr, log_q[lb+6].addr);
      else passed++;
    end
    nrd0 = 0; nrd8 = 0;
    for (int i = lb; i < log_q.size(); i++) begin
      if (!log_q[i].wr && log_q[i].addr == 12'd0) begin
        if (nrd0 < 3) pc[nrd0] = log_q[i].cyc;
        nrd0++;
      end
      if (!log_q[i].wr && log_q[i].addr == 12'd8) nrd8++;
    end
    total++;
    if (nrd0 !== 3) $display("FAIL full_poll_reads: got %0d want 3", nrd0);
    else passed++;
    if (nrd0 >= 3) begin
      total++;
      if (pc[1] - pc[0] < 64 || pc[2] - pc[1] < 64)
        $display("FAIL full_poll_gap: got %0d %0d want >=64", pc[1] - pc[0], pc[2] - pc[1]);
      else passed++;
    end
    total++;
    if (nrd8 !== 6) $display("FAIL full_data_reads: got %0d want 6", nrd8);
    else passed++;
    total++;
    if (words.size() - wb !== 6) $display("FAIL full_word_count: got %0d want 6", words.size() - wb);
    else passed++;
    for (int i = 0; i < 6 && wb + i < words.size(); i++) begin
      exp[31:0] = 32'hD000_0000 + 32'(bd + i);
      exp[32]   = (i == 5);
      total++;
      if (words[wb+i] !== exp) $display("FAIL full_word%0d: got %h want %h", i, words[wb+i], exp);
      else passed++;
    end
    total++;
    if (done_cnt - db !== 1) $display("FAIL full_done_count: got %0d want 1", done_cnt - db);
    else passed++;
    total++;
    if (done_cyc !== hs_cyc + 1) $display("FAIL full_done_timing: got %0d want %0d", done_cyc, hs_cyc + 1);
    else passed++;
    total++;
    if (unstable - ub !== 0 || dbl_req - rb !== 0)
      $display("FAIL full_protocol: got unstable %0d dblreq %0d want 0 0", unstable - ub, dbl_req - rb);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL full_idle: got busy %b want 0", busy);
    else passed++;
    rdy_mode = 1'b0;
  endtask

  task automatic test_depth0();
    int lb, db, vb, n, nrd8;
    lb = log_q.size(); db = done_cnt; vb = valid_seen;
    depth = 16'd0; avail_at = poll_cnt;
    pulse_start(16'hBEEF, 1'b1);
    n = 0;
    while (done_cnt == db && n < 500) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    nrd8 = 0;
    for (int i = lb; i < log_q.size(); i++)
      if (!log_q[i].wr && log_q[i].addr == 12'd8) nrd8++;
    total++;
    if (log_q.size() - lb !== 5 || nrd8 !== 0)
      $display("FAIL d0_txns: got %0d txns %0d data reads want 5 0", log_q.size() - lb, nrd8);
    else passed++;
    if (log_q.size() - lb >= 3) begin
      total++;
      if (log_q[lb+1].wdata !== 32'hAAAA_0001)
        $display("FAIL d0_trig_kept: got %h want aaaa0001", log_q[lb+1].wdata);
      else passed++;
      total++;
      if (log_q[lb+2].wdata !== 32'hBEEF_0101)
        $display("FAIL d0_arm_word: got %h want beef0101", log_q[lb+2].wdata);
      else passed++;
    end
    total++;
    if (valid_seen - vb !== 0) $display("FAIL d0_no_valid: got %0d want 0", valid_seen - vb);
    else passed++;
    total++;
    if (done_cnt - db !== 1) $display("FAIL d0_done: got %0d want 1", done_cnt - db);
    else passed++;
  endtask

  task automatic test_abort();
    int lb, wb, db, n, nrd8;
    lb = log_q.size(); wb = words.size(); db = done_cnt;
    depth = 16'd3; avail_at = poll_cnt; lat = 10;
    pulse_start(16'h0001, 1'b0);
    n = 0;
    while (log_q.size() - lb < 7 && n < 500) begin @(negedge clk); n++; end
    @(posedge clk); #1; cmd_abort = 1'b1;
    @(posedge clk); #1; cmd_abort = 1'b0;
    n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    nrd8 = 0;
    for (int i = lb; i < log_q.size(); i++)
      if (!log_q[i].wr && log_q[i].addr == 12'd8) nrd8++;
    total++;
    if (log_q.size() - lb !== 8 || nrd8 !== 2)
      $display("FAIL abort_txns: got %0d txns %0d data reads want 8 2", log_q.size() - lb, nrd8);
    else passed++;
    if (log_q.size() > 0) begin
      total++;
      if ({log_q[$].wr, log_q[$].addr, log_q[$].wdata} !== {1'b1, 12'd0, 32'h2})
        $display("FAIL abort_write: got %b %0d %h want 1 0 2", log_q[$].wr, log_q[$].addr, log_q[$].wdata);
      else passed++;
    end
    total++;
    if (words.size() - wb !== 1) $display("FAIL abort_words: got %0d want 1", words.size() - wb);
    else passed++;
    total++;
    if ({busy, done_cnt != db, error, out_valid} !== 4'b0)
      $display("FAIL abort_flags: got %b want 0000", {busy, done_cnt != db, error, out_valid});
    else passed++;
    lat = 1;
  endtask

  task automatic test_err();
    int lb, db, n;
    lb = log_q.size(); db = done_cnt;
    err_arm = 1'b1; avail_at = poll_cnt;
    pulse_start(16'h0002, 1'b0);
    n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    total++;
    if ({error, busy} !== 2'b10) $display("FAIL err_flags: got error %b busy %b want 1 0", error, busy);
    else passed++;
    repeat (100) @(negedge clk);
    total++;
    if (log_q.size() - lb !== 3) $display("FAIL err_no_more_req: got %0d txns want 3", log_q.size() - lb);
    else passed++;
    total++;
    if (done_cnt - db !== 0) $display("FAIL err_no_done: got %0d want 0", done_cnt - db);
    else passed++;
    err_arm = 1'b0;
  endtask

  task automatic test_timeout();
    int lb, db, n, errc, diff;
    lb = log_q.size();
    no_ack = 1'b1;
    pulse_start(16'h0003, 1'b0);
    @(negedge clk);
    total++;
    if (error !== 1'b0) $display("FAIL start_clears_err: got %b want 0", error);
    else passed++;
    n = 0;
    while (!error && n < 300) begin @(negedge clk); n++; end
    errc = cyc;
    diff = (log_q.size() > lb) ? errc - log_q[lb].cyc : -1;
    total++;
    if (diff < ACKTO || diff > ACKTO + 1)
      $display("FAIL timeout_latency: got %0d want %0d..%0d", diff, ACKTO, ACKTO + 1);
    else passed++;
    total++;
    if ({error, busy} !== 2'b10) $display("FAIL timeout_flags: got error %b busy %b want 1 0", error, busy);
    else passed++;
    no_ack = 1'b0;
    repeat (5) @(negedge clk);
    db = done_cnt; depth = 16'd0; avail_at = poll_cnt;
    pulse_start(16'h0004, 1'b0);
    @(negedge clk);
    total++;
    if (error !== 1'b0) $display("FAIL restart_clears_err: got %b want 0", error);
    else passed++;
    n = 0;
    while (done_cnt == db && n < 500) begin @(negedge clk); n++; end
    total++;
    if (done_cnt - db !== 1) $display("FAIL restart_done: got %0d want 1", done_cnt - db);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_full();
    test_depth0();
    test_abort();
    test_err();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
